// File: rtl/display_buf_writer.sv
// display_buf_writer
//   Host-side write stage for a Buf0/Buf1 ping-pong frame buffer pair.
//   Host words (WData qualified by CSDisplay) are steered into Buf0 and Buf1
//   in strict alternation. The block generates registered write enables,
//   addresses and data, and tracks which buffers hold a complete frame.
//   The host is throttled through WReady while the next buffer in the
//   rotation is still held by the display side.
//
//   Optional feature: define DROP_CNT_EN to add a 16-bit saturating DropCnt
//   output that counts cycles where the host strobed while WReady was low.
//   Without the macro the port is absent and dropped writes are silent.

module display_buf_writer #(
   parameter int ADDR_W      = 20,
   parameter int FRAME_WORDS = 307200
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       WData,
   input  logic              CSDisplay,
   output logic              WReady,
   input  logic              Buf0Empty,
   input  logic              Buf1Empty,
   output logic              WE0,
   output logic              WE1,
   output logic [ADDR_W-1:0] Addr0,
   output logic [ADDR_W-1:0] Addr1,
   output logic [31:0]       BufData,
   output logic              Buf0Full,
   output logic              Buf1Full,
   output logic              FrameDone
`ifdef DROP_CNT_EN
   ,
   output logic [15:0]       DropCnt
`endif
);

   // Write-side states. FILLx accepts host words into Bufx; WAITx means Bufx
   // is the next buffer in rotation but still holds an unread frame.
   localparam logic [1:0] S_FILL0 = 2'd0;
   localparam logic [1:0] S_FILL1 = 2'd1;
   localparam logic [1:0] S_WAIT0 = 2'd2;
   localparam logic [1:0] S_WAIT1 = 2'd3;

   // Address of the last word of a frame; the pointer wraps after it.
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_WORDS - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic              r_we0;
   logic              r_we1;
   logic [ADDR_W-1:0] r_addr0;
   logic [ADDR_W-1:0] r_addr1;
   logic [31:0]       r_buf_data;
   logic              r_full0;
   logic              r_full1;
   logic              r_fin0_pend;   // final word of a Buf0 frame is being written this cycle
   logic              r_fin1_pend;   // final word of a Buf1 frame is being written this cycle
   logic              r_frame_done;

   // ------------------------------------------------------------------
   // Combinational decode
   // ------------------------------------------------------------------
   logic              w_ready;
   logic              w_accept;
   logic              w_in_fill0;
   logic              w_in_fill1;
   logic              w_last;
   logic              w_final;
   logic              w_full0_nxt;
   logic              w_full1_nxt;
   logic [1:0]        w_state_nxt;
   logic [ADDR_W-1:0] w_wr_ptr_nxt;

   assign w_in_fill0 = (r_state == S_FILL0);
   assign w_in_fill1 = (r_state == S_FILL1);
   assign w_ready    = w_in_fill0 | w_in_fill1;
   assign w_accept   = CSDisplay & w_ready;
   assign w_last     = (r_wr_ptr == LAST_PTR);
   assign w_final    = w_accept & w_last;

   // Next Buf0 full flag: a frame completing this cycle wins over a release,
   // since that release can only refer to an older frame.
   always_comb begin
      w_full0_nxt = r_full0;
      if (r_fin0_pend) begin
         w_full0_nxt = 1'b1;
      end else if (Buf0Empty) begin
         w_full0_nxt = 1'b0;
      end else begin
         w_full0_nxt = r_full0;
      end
   end

   // Next Buf1 full flag, same priority as Buf0.
   always_comb begin
      w_full1_nxt = r_full1;
      if (r_fin1_pend) begin
         w_full1_nxt = 1'b1;
      end else if (Buf1Empty) begin
         w_full1_nxt = 1'b0;
      end else begin
         w_full1_nxt = r_full1;
      end
   end

   // Next state: alternate buffers after each final word; wait whenever the
   // next buffer is still full. Using the next-cycle full flag lets a release
   // coincident with the final accept skip the WAIT state entirely, and makes
   // WAITx leave on the very edge where Bufx full clears.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FILL0: begin
            if (w_final) begin
               if (w_full1_nxt) begin
                  w_state_nxt = S_WAIT1;
               end else begin
                  w_state_nxt = S_FILL1;
               end
            end else begin
               w_state_nxt = S_FILL0;
            end
         end
         S_FILL1: begin
            if (w_final) begin
               if (w_full0_nxt) begin
                  w_state_nxt = S_WAIT0;
               end else begin
                  w_state_nxt = S_FILL0;
               end
            end else begin
               w_state_nxt = S_FILL1;
            end
         end
         S_WAIT0: begin
            if (w_full0_nxt) begin
               w_state_nxt = S_WAIT0;
            end else begin
               w_state_nxt = S_FILL0;
            end
         end
         S_WAIT1: begin
            if (w_full1_nxt) begin
               w_state_nxt = S_WAIT1;
            end else begin
               w_state_nxt = S_FILL1;
            end
         end
         default: begin
            w_state_nxt = S_FILL0;
         end
      endcase
   end

   // Next write pointer: one step per accepted word, wrapping after the last word.
   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      if (w_accept) begin
         if (w_last) begin
            w_wr_ptr_nxt = PTR_ZERO;
         end else begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
         end
      end else begin
         w_wr_ptr_nxt = r_wr_ptr;
      end
   end

   // ------------------------------------------------------------------
   // Sequential logic
   // ------------------------------------------------------------------

   // FSM state and write pointer; reset discards any partial frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_FILL0;
         r_wr_ptr <= PTR_ZERO;
      end else begin
         r_state  <= w_state_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
      end
   end

   // Buffer write port: one-cycle registered copy of each accepted word.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_we0      <= 1'b0;
         r_we1      <= 1'b0;
         r_addr0    <= PTR_ZERO;
         r_addr1    <= PTR_ZERO;
         r_buf_data <= 32'h0000_0000;
      end else begin
         r_we0 <= w_accept & w_in_fill0;
         r_we1 <= w_accept & w_in_fill1;
         if (w_accept & w_in_fill0) begin
            r_addr0 <= r_wr_ptr;
         end else begin
            r_addr0 <= r_addr0;
         end
         if (w_accept & w_in_fill1) begin
            r_addr1 <= r_wr_ptr;
         end else begin
            r_addr1 <= r_addr1;
         end
         if (w_accept) begin
            r_buf_data <= WData;
         end else begin
            r_buf_data <= r_buf_data;
         end
      end
   end

   // Frame completion: the pending flag delays Full by one cycle so the last
   // word is already in RAM when the display side sees the buffer as full.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fin0_pend  <= 1'b0;
         r_fin1_pend  <= 1'b0;
         r_full0      <= 1'b0;
         r_full1      <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_fin0_pend  <= w_final & w_in_fill0;
         r_fin1_pend  <= w_final & w_in_fill1;
         r_full0      <= w_full0_nxt;
         r_full1      <= w_full1_nxt;
         r_frame_done <= r_fin0_pend | r_fin1_pend;
      end
   end

`ifdef DROP_CNT_EN
   logic [15:0] r_drop_cnt;

   // Saturating count of host strobes that arrived while throttled.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_drop_cnt <= 16'h0000;
      end else if (CSDisplay & ~w_ready & (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'h0001;
      end else begin
         r_drop_cnt <= r_drop_cnt;
      end
   end

   assign DropCnt = r_drop_cnt;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign WReady    = w_ready;
   assign WE0       = r_we0;
   assign WE1       = r_we1;
   assign Addr0     = r_addr0;
   assign Addr1     = r_addr1;
   assign BufData   = r_buf_data;
   assign Buf0Full  = r_full0;
   assign Buf1Full  = r_full1;
   assign FrameDone = r_frame_done;

endmodule

// File: tb/tb_display_buf_writer.sv
// tb_display_buf_writer
//   Two instances share one stimulus stream: A with a 4-word frame and
//   B with a 15-word frame in a 4-bit address space (pointer wrap 14->0).
//   A reference model tracks target buffer, word count and full flags per
//   instance and predicts every output after each clock edge.

module tb_display_buf_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] WData;
   logic        CSDisplay;
   logic        Buf0Empty;
   logic        Buf1Empty;

   logic        a_rdy, a_we0, a_we1, a_f0, a_f1, a_fd;
   logic [3:0]  a_ad0, a_ad1;
   logic [31:0] a_bd;
   logic        b_rdy, b_we0, b_we1, b_f0, b_f1, b_fd;
   logic [3:0]  b_ad0, b_ad1;
   logic [31:0] b_bd;
`ifdef DROP_CNT_EN
   logic [15:0] a_drop, b_drop;
`endif

   always #5 clk = ~clk;

   display_buf_writer #(.ADDR_W(4), .FRAME_WORDS(4)) dut_a (
      .clk(clk), .reset(reset), .WData(WData), .CSDisplay(CSDisplay),
      .WReady(a_rdy), .Buf0Empty(Buf0Empty), .Buf1Empty(Buf1Empty),
      .WE0(a_we0), .WE1(a_we1), .Addr0(a_ad0), .Addr1(a_ad1),
      .BufData(a_bd), .Buf0Full(a_f0), .Buf1Full(a_f1), .FrameDone(a_fd)
`ifdef DROP_CNT_EN
      , .DropCnt(a_drop)
`endif
   );

   display_buf_writer #(.ADDR_W(4), .FRAME_WORDS(15)) dut_b (
      .clk(clk), .reset(reset), .WData(WData), .CSDisplay(CSDisplay),
      .WReady(b_rdy), .Buf0Empty(Buf0Empty), .Buf1Empty(Buf1Empty),
      .WE0(b_we0), .WE1(b_we1), .Addr0(b_ad0), .Addr1(b_ad1),
      .BufData(b_bd), .Buf0Full(b_f0), .Buf1Full(b_f1), .FrameDone(b_fd)
`ifdef DROP_CNT_EN
      , .DropCnt(b_drop)
`endif
   );

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model state, one slot per instance.
   int          fw [2] = '{4, 15};
   int          m_tgt [2];
   int          m_cnt [2];
   bit          m_full [2][2];
   bit          m_pend [2][2];
   bit          m_we [2][2];
   logic [3:0]  m_addr [2][2];
   logic [31:0] m_data [2];
   bit          m_fd [2];
   int          m_drop [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d: got %0h want %0h", tag, cyc, obs, exp);
      end
   endtask

   // Predict outputs after one clock edge from the inputs present at that edge.
   task automatic model_step(input bit rst, input bit cs, input logic [31:0] d,
                             input bit e0, input bit e1);
      bit rdy, acc, fin;
      bit emp [2];
      emp[0] = e0;
      emp[1] = e1;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_tgt[k] = 0;
            m_cnt[k] = 0;
            m_data[k] = 32'h0;
            m_fd[k] = 1'b0;
            m_drop[k] = 0;
            for (int b = 0; b < 2; b++) begin
               m_full[k][b] = 1'b0;
               m_pend[k][b] = 1'b0;
               m_we[k][b] = 1'b0;
               m_addr[k][b] = 4'h0;
            end
         end else begin
            rdy = !m_full[k][m_tgt[k]];
            acc = cs && rdy;
            fin = acc && (m_cnt[k] == fw[k] - 1);
            if (cs && !rdy && m_drop[k] < 65535) m_drop[k]++;
            m_fd[k] = m_pend[k][0] || m_pend[k][1];
            for (int b = 0; b < 2; b++) begin
               if (m_pend[k][b]) m_full[k][b] = 1'b1;
               else if (emp[b]) m_full[k][b] = 1'b0;
               m_we[k][b] = acc && (m_tgt[k] == b);
               if (m_we[k][b]) m_addr[k][b] = 4'(m_cnt[k]);
               m_pend[k][b] = fin && (m_tgt[k] == b);
            end
            if (acc) begin
               m_data[k] = d;
               if (fin) begin
                  m_cnt[k] = 0;
                  m_tgt[k] = 1 - m_tgt[k];
               end else begin
                  m_cnt[k]++;
               end
            end
         end
      end
   endtask

   task automatic check_inst(input int k, input logic rdy, input logic we0, input logic we1,
                             input logic [3:0] ad0, input logic [3:0] ad1, input logic [31:0] bd,
                             input logic f0, input logic f1, input logic fd);
      string p;
      p = (k == 0) ? "A" : "B";
      chk({p, ".WReady"}, rdy, !m_full[k][m_tgt[k]]);
      chk({p, ".WE0"}, we0, m_we[k][0]);
      chk({p, ".WE1"}, we1, m_we[k][1]);
      chk({p, ".Addr0"}, ad0, m_addr[k][0]);
      chk({p, ".Addr1"}, ad1, m_addr[k][1]);
      chk({p, ".BufData"}, bd, m_data[k]);
      chk({p, ".Buf0Full"}, f0, m_full[k][0]);
      chk({p, ".Buf1Full"}, f1, m_full[k][1]);
      chk({p, ".FrameDone"}, fd, m_fd[k]);
   endtask

   // One clock: drive inputs, let the edge happen, then compare 1 time unit later.
   task automatic step(input bit rst, input bit cs, input logic [31:0] d,
                       input bit e0, input bit e1);
      reset = rst;
      CSDisplay = cs;
      WData = d;
      Buf0Empty = e0;
      Buf1Empty = e1;
      @(posedge clk);
      cyc++;
      model_step(rst, cs, d, e0, e1);
      #1;
      check_inst(0, a_rdy, a_we0, a_we1, a_ad0, a_ad1, a_bd, a_f0, a_f1, a_fd);
      check_inst(1, b_rdy, b_we0, b_we1, b_ad0, b_ad1, b_bd, b_f0, b_f1, b_fd);
`ifdef DROP_CNT_EN
      chk("A.DropCnt", a_drop, 32'(m_drop[0]));
      chk("B.DropCnt", b_drop, 32'(m_drop[1]));
`endif
   endtask

   initial begin
      int pcs, pemp;
      reset = 1'b1;
      CSDisplay = 1'b0;
      WData = 32'h0;
      Buf0Empty = 1'b0;
      Buf1Empty = 1'b0;

      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      // Two frames back-to-back into Buf0 then Buf1.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
      // Held strobe while waiting for Buf0: dropped.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hBAD0_0000 + 32'(i), 1'b0, 1'b0);
      // Release Buf0, then refill it; release Buf1 on Buf0's final accept.
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'hC000_0003, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'hE000_0000, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      // Reset mid-frame, then spurious release pulses at idle.
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'hF000_0000, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'hF000_0001, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      // Long uninterrupted stream so B wraps its pointer 14 -> 0.
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);

      // Randomized traffic with varying strobe and release densities.
      for (int ph = 0; ph < 6; ph++) begin
         pcs  = 30 + ph * 14;
         pemp = 3 + ph * 4;
         for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 399) == 0,
                 $urandom_range(0, 99) < pcs,
                 $urandom,
                 $urandom_range(0, 99) < pemp,
                 $urandom_range(0, 99) < pemp);
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
